// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: moves a WIDTH-bit operand by a runtime amount, STEP bits per clock.
// Define ITER_SHIFT_ROTATE_EN to make mode 11 rotate left; otherwise mode 11 acts as SLL.
module iter_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt, shifted;
    logic [1:0]       mode, mode_nxt;
    logic [SHW-1:0]   remaining, remaining_nxt, k;
    logic             load_out;

    // Final step may be shorter than STEP when the amount is not a multiple of it.
    always_comb k = (remaining > STEP_AMT) ? STEP_AMT : remaining;

`ifdef ITER_SHIFT_ROTATE_EN
    // Upper half of the doubled word is the operand rotated left by k.
    logic [2*WIDTH-1:0] rot_dbl;
    always_comb rot_dbl = {work, work} << k;
`endif

    always_comb begin
        shifted = work << k;
        case (mode)
            2'b01:   shifted = work >> k;
            2'b10:   shifted = $signed(work) >>> k;
`ifdef ITER_SHIFT_ROTATE_EN
            2'b11:   shifted = rot_dbl[2*WIDTH-1:WIDTH];
`endif
            default: shifted = work << k;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        work_nxt      = work;
        mode_nxt      = mode;
        remaining_nxt = remaining;
        load_out      = 1'b0;
        case (state)
            StShift: begin
                work_nxt      = shifted;
                remaining_nxt = remaining - k;
                if (remaining == k) begin
                    state_nxt = StDone;
                    load_out  = 1'b1;
                end
            end
            default: begin
                if (start_i) begin
                    work_nxt      = data_i;
                    mode_nxt      = mode_i;
                    remaining_nxt = shamt_i;
                    if (shamt_i == '0) begin
                        state_nxt = StDone;
                        load_out  = 1'b1;
                    end else begin
                        state_nxt = StShift;
                    end
                end else begin
                    state_nxt = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= StIdle;
            work      <= '0;
            mode      <= 2'b00;
            remaining <= '0;
            data_o    <= '0;
        end else begin
            state     <= state_nxt;
            work      <= work_nxt;
            mode      <= mode_nxt;
            remaining <= remaining_nxt;
            if (load_out) begin
                data_o <= work_nxt;
            end
        end
    end

    assign busy_o = (state == StShift);
    assign done_o = (state == StDone);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: a STEP=1 and a STEP=4 instance checked against an arithmetic model.
module tb_iter_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] data = '0;
    logic [4:0]  shamt = '0;
    logic        busy1, done1, busy4, done4;
    logic [31:0] out1, out4;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef ITER_SHIFT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    always #5 clk = ~clk;

    iter_shift_unit #(.WIDTH(32), .SHW(5), .STEP(1)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .mode_i(mode), .data_i(data),
        .shamt_i(shamt), .busy_o(busy1), .done_o(done1), .data_o(out1)
    );

    iter_shift_unit #(.WIDTH(32), .SHW(5), .STEP(4)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .mode_i(mode), .data_i(data),
        .shamt_i(shamt), .busy_o(busy4), .done_o(done4), .data_o(out4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d,
                                              input int s);
        case (m)
            2'b01:   return d >> s;
            2'b10:   return d[31] ? ((d >> s) | ~(32'hFFFF_FFFF >> s)) : (d >> s);
            2'b11: begin
                if (!ROT) return d << s;
                return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
            end
            default: return d << s;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        return which ? busy4 : busy1;
    endfunction
    function automatic logic get_done(input int which);
        return which ? done4 : done1;
    endfunction
    function automatic logic [31:0] get_out(input int which);
        return which ? out4 : out1;
    endfunction

    // One full operation on the selected instance, checking result, latency and busy span.
    task automatic run_op(input int which, input logic [1:0] m, input logic [31:0] d,
                          input int s, input string tag);
        int step;
        int lat;
        int cyc;
        int bcnt;
        bit got;
        logic [31:0] exp;
        logic [31:0] prev;
        step = which ? 4 : 1;
        lat  = (s + step - 1) / step + 1;
        exp  = ref_shift(m, d, s);
        prev = get_out(which);
        @(negedge clk);
        mode  = m;
        data  = d;
        shamt = s[4:0];
        if (which != 0) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
        cyc  = 1;
        bcnt = 0;
        got  = 1'b0;
        while (cyc <= 40) begin
            if (get_done(which)) begin
                got = 1'b1;
                break;
            end
            if (get_busy(which)) bcnt++;
            check({tag, " hold"}, get_out(which), prev);
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(lat));
        check({tag, " result"}, get_out(which), exp);
        check({tag, " busy cycles"}, 32'(bcnt), 32'(lat - 1));
        @(posedge clk); #1;
        check({tag, " done pulse"}, {31'b0, get_done(which)}, 32'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst busy1", {31'b0, busy1}, 32'd0);
        check("rst done1", {31'b0, done1}, 32'd0);
        check("rst out1", out1, 32'd0);
        check("rst out4", out4, 32'd0);
        rst = 1'b0;

        run_op(0, 2'b00, 32'h0000_0001, 2, "sll2");
        run_op(0, 2'b10, 32'h8000_0000, 31, "sra31");
        run_op(0, 2'b01, 32'h8000_0000, 31, "srl31");
        for (int m = 0; m < 4; m++) begin
            run_op(0, 2'(m), 32'hDEAD_BEEF, 0, "zero1");
            run_op(1, 2'(m), 32'hDEAD_BEEF, 0, "zero4");
        end

        // Restart attempt mid-SHIFT is ignored; a start in the DONE cycle is accepted.
        @(negedge clk);
        mode = 2'b01; data = 32'h0000_00FF; shamt = 5'd4; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        @(posedge clk); #1;
        cyc++;
        mode = 2'b00; data = 32'h1234_5678; shamt = 5'd3; start1 = 1'b1;
        @(posedge clk); #1;
        cyc++;
        start1 = 1'b0;
        while (!done1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ignore latency", 32'(cyc), 32'd5);
        check("ignore result", out1, 32'h0000_000F);
        mode = 2'b00; data = 32'h0000_0003; shamt = 5'd1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("b2b busy", {31'b0, busy1}, 32'd1);
        check("b2b hold", out1, 32'h0000_000F);
        @(posedge clk); #1;
        check("b2b done", {31'b0, done1}, 32'd1);
        check("b2b result", out1, 32'h0000_0006);

        // Reset three cycles into a long shift discards the operation.
        @(negedge clk);
        mode = 2'b00; data = 32'h0000_0001; shamt = 5'd20; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", {31'b0, busy1}, 32'd0);
        check("midrst done", {31'b0, done1}, 32'd0);
        check("midrst out", out1, 32'd0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        check("midrst no done", 32'(ndone), 32'd0);
        run_op(0, 2'b00, 32'h0000_0005, 3, "postrst");

        run_op(1, 2'b11, 32'h8000_0001, 5, "mode11 step4");
        run_op(1, 2'b10, 32'hF000_0000, 7, "sra step4");

        for (int i = 0; i < 30; i++) begin
            run_op(i % 2, 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 31), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
